// File: rtl/bus_decode_wait_if.sv
// Z80 bus signals between the CPU strobes and the bus_decode_wait cycle decoder.
// The master side drives address and strobes; the slave side returns selects and WAIT.
interface bus_decode_wait_if;
    logic [15:0] addr;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic        cs_rom;
    logic        cs_ram;
    logic        cs_io;
    logic [1:0]  rdsel;
    logic        rd_oe;
    logic        wr_stb;
    logic        wait_n;

    modport master (
        output addr, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        input  cs_rom, cs_ram, cs_io, rdsel, rd_oe, wr_stb, wait_n
    );

    modport slave (
        input  addr, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
        output cs_rom, cs_ram, cs_io, rdsel, rd_oe, wr_stb, wait_n
    );
endinterface

// File: rtl/bus_decode_wait.sv
// Z80 bus cycle decoder and per-region wait-state generator feeding the read-data mux.
// Optional: define BUS_DECODE_M1_WAIT_EN to add one wait state to opcode-fetch cycles.
module bus_decode_wait #(
    parameter logic [15:0] ROM_END  = 16'h3FFF,
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_decode_wait_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE
    } state_t;

    // Region codes double as the rdsel value that steers the read-data mux.
    typedef enum logic [1:0] {
        R_ROM  = 2'b00,
        R_RAM  = 2'b01,
        R_IO   = 2'b10,
        R_INTA = 2'b11
    } region_t;

    localparam logic [3:0] ROM_CNT = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_CNT = 4'(RAM_WAIT);
    localparam logic [3:0] IO_CNT  = 4'(IO_WAIT);

`ifdef BUS_DECODE_M1_WAIT_EN
    localparam logic [3:0] ROM_CNT_M1 = (ROM_CNT == 4'hF) ? 4'hF : ROM_CNT + 4'd1;
    localparam logic [3:0] RAM_CNT_M1 = (RAM_CNT == 4'hF) ? 4'hF : RAM_CNT + 4'd1;
`else
    localparam logic [3:0] ROM_CNT_M1 = ROM_CNT;
    localparam logic [3:0] RAM_CNT_M1 = RAM_CNT;
`endif

    state_t      state_q, state_d;
    region_t     region_q, region_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_done_q, wr_done_d;

    logic        cs_rom_q, cs_rom_d;
    logic        cs_ram_q, cs_ram_d;
    logic        cs_io_q, cs_io_d;
    logic [1:0]  rdsel_q, rdsel_d;
    logic        rd_oe_q, rd_oe_d;
    logic        wr_stb_q, wr_stb_d;
    logic        wait_n_q, wait_n_d;

    logic        start;
    logic        bus_held;
    logic        in_cycle;
    region_t     start_region;
    logic [3:0]  start_cnt;

    assign start    = (!bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n)) || !bus.iorq_n;
    assign bus_held = !bus.mreq_n || !bus.iorq_n;
    assign in_cycle = (state_q != S_IDLE) && bus_held;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        start_region = R_RAM;
        start_cnt    = RAM_CNT;
        if (!bus.iorq_n && !bus.m1_n) begin
            start_region = R_INTA;
            start_cnt    = IO_CNT;
        end else if (!bus.iorq_n) begin
            start_region = R_IO;
            start_cnt    = IO_CNT;
        end else if (bus.addr <= ROM_END) begin
            start_region = R_ROM;
            start_cnt    = bus.m1_n ? ROM_CNT : ROM_CNT_M1;
        end else begin
            start_region = R_RAM;
            start_cnt    = bus.m1_n ? RAM_CNT : RAM_CNT_M1;
        end
    end

    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        cnt_d     = cnt_q;
        wr_done_d = wr_done_q;
        case (state_q)
            S_IDLE: begin
                wr_done_d = 1'b0;
                if (start) begin
                    region_d = start_region;
                    cnt_d    = start_cnt;
                    state_d  = (start_cnt == 4'd0) ? S_ACTIVE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus_held) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!bus_held)       state_d   = S_IDLE;
                else if (!bus.wr_n)  wr_done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one edge.
    always_comb begin
        cs_rom_d = in_cycle && (region_q == R_ROM);
        cs_ram_d = in_cycle && (region_q == R_RAM);
        cs_io_d  = in_cycle && (region_q == R_IO);
        rdsel_d  = (state_q != S_IDLE) ? region_q : rdsel_q;
        wait_n_d = !((state_q == S_WAIT) && bus_held);
        rd_oe_d  = (state_q == S_ACTIVE) && bus_held &&
                   ((region_q == R_INTA) || !bus.rd_n);
        wr_stb_d = (state_q == S_ACTIVE) && bus_held && (region_q != R_INTA) &&
                   !bus.wr_n && !wr_done_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            region_q  <= R_ROM;
            cnt_q     <= 4'd0;
            wr_done_q <= 1'b0;
            cs_rom_q  <= 1'b0;
            cs_ram_q  <= 1'b0;
            cs_io_q   <= 1'b0;
            rdsel_q   <= 2'b00;
            rd_oe_q   <= 1'b0;
            wr_stb_q  <= 1'b0;
            wait_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            cnt_q     <= cnt_d;
            wr_done_q <= wr_done_d;
            cs_rom_q  <= cs_rom_d;
            cs_ram_q  <= cs_ram_d;
            cs_io_q   <= cs_io_d;
            rdsel_q   <= rdsel_d;
            rd_oe_q   <= rd_oe_d;
            wr_stb_q  <= wr_stb_d;
            wait_n_q  <= wait_n_d;
        end
    end

    assign bus.cs_rom = cs_rom_q;
    assign bus.cs_ram = cs_ram_q;
    assign bus.cs_io  = cs_io_q;
    assign bus.rdsel  = rdsel_q;
    assign bus.rd_oe  = rd_oe_q;
    assign bus.wr_stb = wr_stb_q;
    assign bus.wait_n = wait_n_q;

    // A write strobe only ever follows the wait phase, and at most one select is live.
    a_no_strobe_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.wr_stb && !bus.wait_n));
    a_onehot_cs : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({bus.cs_rom, bus.cs_ram, bus.cs_io}));

endmodule

// File: doc/bus_decode_wait.md
# bus_decode_wait

Z80 bus cycle decoder and wait-state generator sitting directly upstream of the read-data `mux4`. Classifies each bus cycle as ROM, RAM, I/O or interrupt acknowledge, drives the chip selects and the 2-bit `rdsel` that steers the read-data mux, and inserts a per-region programmable number of wait states on `wait_n`. All outputs are registered in the system clock domain; CPU strobes arrive already synchronised to `clk`.

## Interface
- `ROM_END`, 16'h3FFF: highest ROM address; memory addresses above it are RAM.
- `ROM_WAIT`, 1: wait states for ROM cycles, 0..15.
- `RAM_WAIT`, 0: wait states for RAM cycles, 0..15.
- `IO_WAIT`, 2: wait states for I/O and interrupt-ack cycles, 0..15.

- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `addr`  in  16  CPU address bus.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `rfsh_n`  in  1 each  CPU control strobes, active-low.
- `cs_rom`, `cs_ram`, `cs_io`  out  1 each  chip selects, active-high.
- `rdsel`  out  2  read-data mux select: 00 ROM, 01 RAM, 10 I/O, 11 interrupt vector.
- `rd_oe`  out  1  read data valid to CPU; drives data-bus output enable.
- `wr_stb`  out  1  single-cycle write strobe to the selected region.
- `wait_n`  out  1  CPU WAIT, active-low.

## Operation
- States: IDLE, WAIT, ACTIVE.
- IDLE: start condition = (`mreq_n`=0 and `rfsh_n`=1 and (`rd_n`=0 or `wr_n`=0)) or `iorq_n`=0. Refresh cycles (`rfsh_n`=0) never start a cycle.
- On start: latch region and `addr`-derived decode; priority intack (`iorq_n`=0 and `m1_n`=0) > I/O (`iorq_n`=0) > memory (`addr` <= `ROM_END` → ROM, else RAM). Load 4-bit counter with region wait count.
- Counter 0 → ACTIVE; else → WAIT with `wait_n`=0.
- WAIT: decrement each cycle; on reaching 0 go ACTIVE, `wait_n`=1.
- ACTIVE: hold cs and `rdsel`; `rd_oe`=1 while `rd_n`=0 (or always for intack); `wr_stb`=1 for exactly the first ACTIVE cycle with `wr_n`=0. Exit to IDLE when `mreq_n`=1 and `iorq_n`=1.
- Strobes deassert during WAIT: abort to IDLE, drop cs, `wait_n`=1, no `wr_stb`.
- `addr` changes after start ignored until IDLE.
- Intack: `cs_*` all 0, `rdsel`=11, `rd_oe`=1 in ACTIVE.

## Timing
- Reset (`rst_n`=0 at rising `clk`): state IDLE, `cs_*`=0, `rdsel`=00, `rd_oe`=0, `wr_stb`=0, `wait_n`=1, counter 0. Reset mid-cycle aborts immediately, same values next edge.
- Start sampled at edge T: cs/`rdsel` valid after T+1; `wait_n` low T+1..T+N, high after T+1+N; `rd_oe`/`wr_stb` first asserted T+1+N.
- Exit: strobes high at edge E → all cs/`rd_oe` 0 after E+1; `rdsel` holds last value.
- Minimum one IDLE cycle between bus cycles; a start seen on the IDLE-return edge is taken on the next edge.

## Configuration
- `BUS_DECODE_M1_WAIT_EN` defined: opcode-fetch memory cycles (`m1_n`=0, `mreq_n`=0) get one extra wait state beyond `ROM_WAIT`/`RAM_WAIT` (saturating at 15).
- Undefined: M1 fetches use the plain region wait count; `m1_n` only used for intack detection.

## Test plan
- Reset: hold `rst_n`=0 with `mreq_n`=0, `rd_n`=0 → `cs_*`=0, `wait_n`=1, `rdsel`=00, `rd_oe`=0.
- ROM read `addr`=16'h0100, defaults → `cs_rom`=1, `rdsel`=00, `wait_n` low exactly 1 cycle, then `rd_oe`=1 until `mreq_n` rises.
- RAM write `addr`=16'h8000, `RAM_WAIT`=0 → `cs_ram`=1, `wait_n` never low, `wr_stb` high exactly 1 cycle.
- I/O read then intack (`iorq_n`=0, `m1_n`=0) → `cs_io`=1/`rdsel`=10 with 2 wait cycles; then `rdsel`=11, all cs 0, `rd_oe`=1.
- Refresh (`mreq_n`=0, `rfsh_n`=0) → no cs, `wait_n`=1; strobes dropped mid-WAIT with `IO_WAIT`=5 → IDLE next cycle, no `wr_stb`.
- With `BUS_DECODE_M1_WAIT_EN`: M1 fetch at 16'h0000 → `wait_n` low 2 cycles; without: 1 cycle.
